addsubcmp_threshold_monitor: RTL and testbench
==============================================

ADDSUBCMP_THRESHOLD_MONITOR -- requirements
Module: addsubcmp_threshold_monitor

Interface
REQ-001 Parameter: Width, 16, operand width in bits (legal 2..32).
REQ-002 Parameter: CntWidth, 8, width of persistence counter and Persist_i (legal 1..16).
REQ-003 Port: Clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 Port: Reset_i  in  1  reset, synchronous, active-high.
REQ-005 Port: Enable_i  in  1  monitor enable; low forces IDLE.
REQ-006 Port: Valid_i  in  1  sample strobe; A_i/B_i/Mode_i/Signed_i/Persist_i sampled when Valid_i & Enable_i.
REQ-007 Port: A_i  in  Width  sample operand.
REQ-008 Port: B_i  in  Width  threshold operand.
REQ-009 Port: Mode_i  in  2  00 A>B, 01 A>=B, 10 A<B, 11 A==B.
REQ-010 Port: Signed_i  in  1  1 = two's-complement compare, 0 = unsigned.
REQ-011 Port: Persist_i  in  CntWidth  consecutive true samples required to trigger; 0 treated as 1.
REQ-012 Port: Result_o  out  1  registered compare result of last accepted sample.
REQ-013 Port: ResultValid_o  out  1  one-cycle pulse, Result_o updated.
REQ-014 Port: Count_o  out  CntWidth  current consecutive-true count, saturating.
REQ-015 Port: Event_o  out  1  one-cycle pulse on IDLE/ARMED->TRIGGERED.
REQ-016 Port: Active_o  out  1  high while in TRIGGERED.

Function
REQ-017 Compare SHALL use one Width+1-bit subtraction A-B; unsigned greater = no borrow & nonzero; signed greater = (sign XOR overflow)==0 & nonzero; equal = zero difference.
REQ-018 Accepted sample (Valid_i=1, Enable_i=1 at edge k) SHALL update Result_o, pulse ResultValid_o, update Count_o at edge k (visible cycle after k); latency 1 cycle.
REQ-019 Cycles with Valid_i=0 SHALL hold Result_o, Count_o, state; ResultValid_o and Event_o low.
REQ-020 Count: true sample -> Count+1, saturating at 2^CntWidth-1; false sample -> 0.
REQ-021 FSM states: IDLE, ARMED, TRIGGERED; state register SHALL be observable only via Active_o.
REQ-022 IDLE -> ARMED on first edge with Enable_i=1 (sample on that edge processed normally).
REQ-023 ARMED -> TRIGGERED when updated count >= max(Persist_i,1); Event_o pulses same edge.
REQ-024 TRIGGERED -> ARMED on accepted false sample; Event_o not asserted on exit.
REQ-025 In TRIGGERED further true samples SHALL NOT re-pulse Event_o.
REQ-026 Enable_i=0 at any edge: state IDLE, Count_o=0, ResultValid_o=0, Event_o=0, Active_o=0; Result_o held; Valid_i ignored.
REQ-027 Mode_i/Signed_i/Persist_i changes SHALL take effect on next accepted sample without clearing Count_o.
REQ-028 Persist_i lowered below current count while ARMED: trigger on next accepted true sample.

Reset
REQ-029 Reset_i=1 at an edge SHALL set state IDLE, Result_o=0, ResultValid_o=0, Count_o=0, Event_o=0, Active_o=0; overrides Enable_i and Valid_i.
REQ-030 Reset asserted mid-count or in TRIGGERED SHALL discard count without pulsing Event_o; first accepted sample after release starts count from 0.

Verification
REQ-031 Width=16, Mode=00, Signed=0, A=0x8000, B=0x7FFF, one Valid -> Result_o=1, ResultValid_o pulse 1 cycle; Signed=1 same values -> Result_o=0.
REQ-032 Mode=11, Persist=3, A=B=0x1234 on 3 valid samples with Valid gaps between -> Count 1,2,3; Event_o single pulse at 3rd; Active_o=1.
REQ-033 TRIGGERED, then A=0x0001,B=0x0002, Mode=00 valid -> Count_o=0, Active_o=0, no Event_o; Persist=0 then one true sample -> Event_o pulse.
REQ-034 CntWidth=2, Persist=3, 6 consecutive true samples -> Count_o 1,2,3,3,3,3; exactly one Event_o.
REQ-035 Count=2 of Persist=4, Reset_i pulse one cycle -> all outputs 0; Enable_i=0 mid-count -> Count_o=0, Active_o=0, Result_o held.
REQ-036 Mode sweep 00/01/10/11 on (A,B) = (5,5),(6,5),(4,5) unsigned and (0xFFFF,0x0001) signed -> Result_o matches golden compare every sample.

Source files
------------

// File: rtl/addsubcmp_threshold_monitor.sv
// addsubcmp_threshold_monitor
//   Compares a sample operand A_i against a threshold B_i using a single
//   Width+1-bit subtraction, then tracks how many consecutive accepted
//   samples satisfied the selected relation. Once that run reaches the
//   persistence threshold the monitor enters TRIGGERED and pulses Event_o.
//
// Ports
//   Clk_i          clock, all state updates on the rising edge
//   Reset_i        synchronous active-high reset
//   Enable_i       monitor enable; low forces IDLE and clears the count
//   Valid_i        sample strobe (accepted when Enable_i is also high)
//   A_i, B_i       sample and threshold operands
//   Mode_i         00 A>B, 01 A>=B, 10 A<B, 11 A==B
//   Signed_i       1 = two's-complement compare, 0 = unsigned
//   Persist_i      consecutive true samples needed to trigger (0 acts as 1)
//   Result_o       registered compare result of the last accepted sample
//   ResultValid_o  one-cycle pulse when Result_o was updated
//   Count_o        saturating consecutive-true count
//   Event_o        one-cycle pulse on entry to TRIGGERED
//   Active_o       high while TRIGGERED
module addsubcmp_threshold_monitor #(
  parameter int Width    = 16,
  parameter int CntWidth = 8
) (
  input  logic                Clk_i,
  input  logic                Reset_i,
  input  logic                Enable_i,
  input  logic                Valid_i,
  input  logic [Width-1:0]    A_i,
  input  logic [Width-1:0]    B_i,
  input  logic [1:0]          Mode_i,
  input  logic                Signed_i,
  input  logic [CntWidth-1:0] Persist_i,
  output logic                Result_o,
  output logic                ResultValid_o,
  output logic [CntWidth-1:0] Count_o,
  output logic                Event_o,
  output logic                Active_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_TRIG  = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic                result_r, result_s;
  logic                result_valid_r, result_valid_s;
  logic [CntWidth-1:0] count_r, count_s;
  logic                event_r, event_s;

  logic [Width:0]      diff_s;
  logic                zero_s;
  logic                ovf_s;
  logic                gt_s;
  logic                cmp_s;
  logic [CntWidth-1:0] persist_eff_s;
  logic [CntWidth-1:0] count_inc_s;

  // Relation evaluation from one extended subtraction.
  always_comb begin
    diff_s = {1'b0, A_i} - {1'b0, B_i};
    zero_s = (diff_s[Width-1:0] == {Width{1'b0}});
    // Signed overflow: operands differ in sign and the result sign differs from A.
    ovf_s  = (A_i[Width-1] ^ B_i[Width-1]) & (diff_s[Width-1] ^ A_i[Width-1]);
    if (Signed_i) begin
      gt_s = ~(diff_s[Width-1] ^ ovf_s) & ~zero_s;
    end else begin
      gt_s = ~diff_s[Width] & ~zero_s;
    end
    case (Mode_i)
      2'b00:   cmp_s = gt_s;
      2'b01:   cmp_s = gt_s | zero_s;
      2'b10:   cmp_s = ~gt_s & ~zero_s;
      2'b11:   cmp_s = zero_s;
      default: cmp_s = 1'b0;
    endcase
  end

  // Effective persistence threshold and saturating count increment.
  always_comb begin
    if (Persist_i == {CntWidth{1'b0}}) begin
      persist_eff_s = CntWidth'(1);
    end else begin
      persist_eff_s = Persist_i;
    end
    if (count_r == {CntWidth{1'b1}}) begin
      count_inc_s = count_r;
    end else begin
      count_inc_s = count_r + CntWidth'(1);
    end
  end

  // Next-state and next-output logic for the monitor FSM.
  always_comb begin
    state_s        = state_r;
    result_s       = result_r;
    result_valid_s = 1'b0;
    count_s        = count_r;
    event_s        = 1'b0;
    if (!Enable_i) begin
      state_s = ST_IDLE;
      count_s = {CntWidth{1'b0}};
    end else if (Valid_i) begin
      result_s       = cmp_s;
      result_valid_s = 1'b1;
      if (cmp_s) begin
        count_s = count_inc_s;
      end else begin
        count_s = {CntWidth{1'b0}};
      end
      case (state_r)
        ST_IDLE, ST_ARMED: begin
          // Compare against the updated count so a lowered threshold fires
          // on the very next true sample.
          if (count_s >= persist_eff_s) begin
            state_s = ST_TRIG;
            event_s = 1'b1;
          end else begin
            state_s = ST_ARMED;
          end
        end
        ST_TRIG: begin
          if (!cmp_s) begin
            state_s = ST_ARMED;
          end else begin
            state_s = ST_TRIG;
          end
        end
        default: state_s = ST_IDLE;
      endcase
    end else begin
      if (state_r == ST_IDLE) begin
        state_s = ST_ARMED;
      end else begin
        state_s = state_r;
      end
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge Clk_i) begin
    if (Reset_i) begin
      state_r        <= ST_IDLE;
      result_r       <= 1'b0;
      result_valid_r <= 1'b0;
      count_r        <= {CntWidth{1'b0}};
      event_r        <= 1'b0;
    end else begin
      state_r        <= state_s;
      result_r       <= result_s;
      result_valid_r <= result_valid_s;
      count_r        <= count_s;
      event_r        <= event_s;
    end
  end

  assign Result_o      = result_r;
  assign ResultValid_o = result_valid_r;
  assign Count_o       = count_r;
  assign Event_o       = event_r;
  assign Active_o      = (state_r == ST_TRIG);

endmodule

// File: tb/tb_addsubcmp_threshold_monitor.sv
module tb_addsubcmp_threshold_monitor;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic        valid = 1'b0;
  logic [15:0] a = 16'd0;
  logic [15:0] b = 16'd0;
  logic [1:0]  mode = 2'd0;
  logic        sgn = 1'b0;
  logic [7:0]  persist = 8'd0;
  logic [1:0]  persist2;

  logic        res1, rv1, ev1, act1;
  logic [7:0]  cnt1;
  logic        res2, rv2, ev2, act2;
  logic [1:0]  cnt2;

  int n_pass = 0;
  int n_total = 0;

  // Reference model state (expected outputs after the next edge).
  bit m_res = 1'b0;
  bit m_rv = 1'b0;
  int m_cnt [2] = '{0, 0};
  bit m_act [2] = '{1'b0, 1'b0};
  bit m_ev  [2] = '{1'b0, 1'b0};

  assign persist2 = persist[1:0];

  always #5 clk = ~clk;

  addsubcmp_threshold_monitor #(.Width(16), .CntWidth(8)) dut1 (
    .Clk_i(clk), .Reset_i(rst), .Enable_i(en), .Valid_i(valid),
    .A_i(a), .B_i(b), .Mode_i(mode), .Signed_i(sgn), .Persist_i(persist),
    .Result_o(res1), .ResultValid_o(rv1), .Count_o(cnt1),
    .Event_o(ev1), .Active_o(act1)
  );

  addsubcmp_threshold_monitor #(.Width(16), .CntWidth(2)) dut2 (
    .Clk_i(clk), .Reset_i(rst), .Enable_i(en), .Valid_i(valid),
    .A_i(a), .B_i(b), .Mode_i(mode), .Signed_i(sgn), .Persist_i(persist2),
    .Result_o(res2), .ResultValid_o(rv2), .Count_o(cnt2),
    .Event_o(ev2), .Active_o(act2)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total = n_total + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Golden relation evaluated on mathematical integer values.
  function automatic bit golden(input logic [1:0] m, input logic s,
                                input logic [15:0] x, input logic [15:0] y);
    longint vx, vy;
    vx = s ? longint'($signed(x)) : longint'(x);
    vy = s ? longint'($signed(y)) : longint'(y);
    case (m)
      2'd0:    return vx > vy;
      2'd1:    return vx >= vy;
      2'd2:    return vx < vy;
      default: return vx == vy;
    endcase
  endfunction

  task automatic model_edge();
    bit r;
    int cmax, p;
    if (rst || !en) begin
      m_rv = 1'b0;
      if (rst) m_res = 1'b0;
      for (int d = 0; d < 2; d++) begin
        m_cnt[d] = 0; m_act[d] = 1'b0; m_ev[d] = 1'b0;
      end
    end else begin
      m_rv = valid;
      r = golden(mode, sgn, a, b);
      if (valid) m_res = r;
      for (int d = 0; d < 2; d++) begin
        m_ev[d] = 1'b0;
        if (valid) begin
          cmax = (d == 0) ? 255 : 3;
          p = (d == 0) ? int'(persist) : int'(persist) % 4;
          if (p == 0) p = 1;
          m_cnt[d] = r ? ((m_cnt[d] < cmax) ? m_cnt[d] + 1 : m_cnt[d]) : 0;
          if (!m_act[d] && m_cnt[d] >= p) begin
            m_act[d] = 1'b1; m_ev[d] = 1'b1;
          end else if (m_act[d] && !r) begin
            m_act[d] = 1'b0;
          end
        end
      end
    end
  endtask

  task automatic check_model();
    chk("m1_result", {31'd0, res1}, {31'd0, m_res});
    chk("m1_rvalid", {31'd0, rv1},  {31'd0, m_rv});
    chk("m1_count",  {24'd0, cnt1}, m_cnt[0]);
    chk("m1_event",  {31'd0, ev1},  {31'd0, m_ev[0]});
    chk("m1_active", {31'd0, act1}, {31'd0, m_act[0]});
    chk("m2_result", {31'd0, res2}, {31'd0, m_res});
    chk("m2_rvalid", {31'd0, rv2},  {31'd0, m_rv});
    chk("m2_count",  {30'd0, cnt2}, m_cnt[1]);
    chk("m2_event",  {31'd0, ev2},  {31'd0, m_ev[1]});
    chk("m2_active", {31'd0, act2}, {31'd0, m_act[1]});
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    #1;
    check_model();
  endtask

  task automatic sample(input logic [1:0] m, input logic s,
                        input logic [15:0] x, input logic [15:0] y);
    mode = m; sgn = s; a = x; b = y; valid = 1'b1;
    cycle();
    valid = 1'b0;
  endtask

  logic       sweep_exp [4][4];
  logic [15:0] sweep_a [4];
  logic [15:0] sweep_b [4];
  int ev_count;
  int exp_cnt2 [6];

  initial begin
    sweep_a = '{16'd5, 16'd6, 16'd4, 16'hFFFF};
    sweep_b = '{16'd5, 16'd5, 16'd5, 16'h0001};
    sweep_exp[0] = '{1'b0, 1'b1, 1'b0, 1'b1};
    sweep_exp[1] = '{1'b1, 1'b1, 1'b0, 1'b0};
    sweep_exp[2] = '{1'b0, 1'b0, 1'b1, 1'b0};
    sweep_exp[3] = '{1'b0, 1'b0, 1'b1, 1'b0};
    exp_cnt2 = '{1, 2, 3, 3, 3, 3};

    // Reset state
    rst = 1'b1; en = 1'b1; valid = 1'b1;
    cycle();
    chk("rst_result", {31'd0, res1}, 32'd0);
    chk("rst_count",  {24'd0, cnt1}, 32'd0);
    chk("rst_active", {31'd0, act1}, 32'd0);
    chk("rst_rvalid", {31'd0, rv1},  32'd0);
    rst = 1'b0; valid = 1'b0;

    // Unsigned vs signed compare of 0x8000 against 0x7FFF
    persist = 8'd5;
    sample(2'b00, 1'b0, 16'h8000, 16'h7FFF);
    chk("uns_gt_result", {31'd0, res1}, 32'd1);
    chk("uns_gt_rvalid", {31'd0, rv1},  32'd1);
    cycle();
    chk("rvalid_one_cycle", {31'd0, rv1}, 32'd0);
    chk("result_hold",      {31'd0, res1}, 32'd1);
    sample(2'b00, 1'b1, 16'h8000, 16'h7FFF);
    chk("sgn_gt_result", {31'd0, res1}, 32'd0);

    // Equality persistence with valid gaps
    persist = 8'd3;
    for (int i = 1; i <= 3; i++) begin
      sample(2'b11, 1'b0, 16'h1234, 16'h1234);
      chk("eq_count", {24'd0, cnt1}, 32'(i));
      chk("eq_event", {31'd0, ev1}, (i == 3) ? 32'd1 : 32'd0);
      cycle();
      chk("gap_event", {31'd0, ev1}, 32'd0);
    end
    chk("eq_active", {31'd0, act1}, 32'd1);

    // Exit TRIGGERED on false sample, then Persist=0 acts as 1
    sample(2'b00, 1'b0, 16'h0001, 16'h0002);
    chk("exit_count",  {24'd0, cnt1}, 32'd0);
    chk("exit_active", {31'd0, act1}, 32'd0);
    chk("exit_event",  {31'd0, ev1},  32'd0);
    persist = 8'd0;
    sample(2'b11, 1'b0, 16'h0007, 16'h0007);
    chk("p0_event", {31'd0, ev1}, 32'd1);

    // Saturation with CntWidth=2
    rst = 1'b1; cycle(); rst = 1'b0;
    persist = 8'd3;
    ev_count = 0;
    for (int i = 0; i < 6; i++) begin
      sample(2'b11, 1'b0, 16'h0042, 16'h0042);
      chk("sat_count", {30'd0, cnt2}, 32'(exp_cnt2[i]));
      ev_count = ev_count + int'(ev2);
    end
    chk("sat_events", 32'(ev_count), 32'd1);

    // Reset and disable in mid-count
    rst = 1'b1; cycle(); rst = 1'b0;
    persist = 8'd4;
    sample(2'b11, 1'b0, 16'h0009, 16'h0009);
    sample(2'b11, 1'b0, 16'h0009, 16'h0009);
    chk("mid_count", {24'd0, cnt1}, 32'd2);
    rst = 1'b1; valid = 1'b1; cycle(); rst = 1'b0; valid = 1'b0;
    chk("midrst_count",  {24'd0, cnt1}, 32'd0);
    chk("midrst_result", {31'd0, res1}, 32'd0);
    chk("midrst_event",  {31'd0, ev1},  32'd0);
    sample(2'b11, 1'b0, 16'h0009, 16'h0009);
    chk("after_rst_count", {24'd0, cnt1}, 32'd1);
    sample(2'b11, 1'b0, 16'h0009, 16'h0009);
    en = 1'b0; valid = 1'b1; cycle(); valid = 1'b0;
    chk("dis_count",  {24'd0, cnt1}, 32'd0);
    chk("dis_active", {31'd0, act1}, 32'd0);
    chk("dis_result", {31'd0, res1}, 32'd1);
    chk("dis_rvalid", {31'd0, rv1},  32'd0);
    en = 1'b1;

    // Mode sweep against golden table
    for (int p = 0; p < 4; p++) begin
      for (int m = 0; m < 4; m++) begin
        sample(2'(m), (p == 3) ? 1'b1 : 1'b0, sweep_a[p], sweep_b[p]);
        chk("sweep_result", {31'd0, res1}, {31'd0, sweep_exp[p][m]});
      end
    end

    // Randomized traffic against the reference model
    for (int i = 0; i < 600; i++) begin
      rst   = ($urandom_range(0, 59) == 0);
      en    = ($urandom_range(0, 24) != 0);
      valid = $urandom_range(0, 2) != 0;
      mode  = 2'($urandom_range(0, 3));
      sgn   = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 15) == 0) persist = 8'($urandom_range(0, 6));
      if ($urandom_range(0, 1) == 0) begin
        a = 16'($urandom_range(0, 7));
        b = 16'($urandom_range(0, 7));
      end else begin
        a = 16'($urandom);
        b = ($urandom_range(0, 3) == 0) ? a : 16'($urandom);
      end
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
